// File: rtl/ep2_axis_pkg.sv
// Shared AXI-Stream merge types: arbiter FSM states and the round-robin grant helper.
package ep2_axis_pkg;

  localparam int MAX_SRC   = 16;
  localparam int SRC_IDX_W = $clog2(MAX_SRC);

  typedef enum logic {
    IDLE,
    LOCKED
  } merge_state_t;

  typedef struct packed {
    logic                 found;
    logic [SRC_IDX_W-1:0] idx;
  } rr_grant_t;

  // Scan last+1, last+2, ... with wrap at n; the nearest valid source wins.
  function automatic rr_grant_t rr_next(
    input logic [MAX_SRC-1:0]   vld,
    input logic [SRC_IDX_W-1:0] last,
    input int                   n
  );
    rr_grant_t r;
    int c;
    r = '0;
    for (int i = MAX_SRC; i >= 1; i--) begin
      if (i <= n) begin
        c = (int'(last) + i) % n;
        if (vld[c[SRC_IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = c[SRC_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Generic 2-entry register slice: output register plus overflow register.
module axis_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic [W-1:0] r_out;
  logic [W-1:0] r_skid;
  logic         r_out_vld;
  logic         r_skid_vld;
  logic         w_push;
  logic         w_pop;

  // Ready comes straight from a flop, so downstream ready never reaches upstream.
  assign o_ready = ~r_skid_vld;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = r_out_vld & i_ready;
  assign o_data  = r_out;
  assign o_valid = r_out_vld;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (r_skid_vld) begin
      if (w_pop) begin
        r_out      <= r_skid;
        r_skid_vld <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_out_vld || w_pop) begin
        r_out     <= i_data;
        r_out_vld <= 1'b1;
      end else begin
        r_skid     <= i_data;
        r_skid_vld <= 1'b1;
      end
    end else if (w_pop) begin
      r_out_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_merge.sv
// N-to-1 AXI-Stream merge with round-robin, frame-locked arbitration.
// Define AXIS_MERGE_SRCID_EN to add m_axis_out_tid (originating source index).
module axis_merge
  import ep2_axis_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int IF_STREAM    = 1,
  parameter int KEEP_WIDTH   = IF_STREAM ? DATA_WIDTH / 8 : 1,
  parameter int SOURCE_COUNT = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SOURCE_COUNT*DATA_WIDTH-1:0] s_axis_in_tdata,
  input  logic [SOURCE_COUNT*KEEP_WIDTH-1:0] s_axis_in_tkeep,
  input  logic [SOURCE_COUNT-1:0]          s_axis_in_tvalid,
  input  logic [SOURCE_COUNT-1:0]          s_axis_in_tlast,
  output logic [SOURCE_COUNT-1:0]          s_axis_in_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_out_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_out_tkeep,
  output logic                             m_axis_out_tvalid,
  input  logic                             m_axis_out_tready,
  output logic                             m_axis_out_tlast
`ifdef AXIS_MERGE_SRCID_EN
  ,
  output logic [$clog2(SOURCE_COUNT)-1:0]  m_axis_out_tid
`endif
);

  localparam int SIW = $clog2(SOURCE_COUNT);
  localparam int BW  = DATA_WIDTH + KEEP_WIDTH + 1;
`ifdef AXIS_MERGE_SRCID_EN
  localparam int PW  = BW + SIW;
`else
  localparam int PW  = BW;
`endif

  merge_state_t    r_state;
  logic [SIW-1:0]  r_grant;
  logic [SIW-1:0]  r_last_grant;

  rr_grant_t       w_rr;
  logic [SIW-1:0]  w_gnt;
  logic            w_gnt_vld;
  logic            w_skid_rdy;
  logic            w_acc;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [KEEP_WIDTH-1:0] w_sel_keep;
  logic            w_sel_last;
  logic [PW-1:0]   w_in;
  logic [PW-1:0]   w_out;

  assign w_rr = rr_next(MAX_SRC'(s_axis_in_tvalid),
                        SRC_IDX_W'(r_last_grant), SOURCE_COUNT);

  // A locked frame owner ignores every other source, even while stalled.
  assign w_gnt     = (r_state == LOCKED) ? r_grant : w_rr.idx[SIW-1:0];
  assign w_gnt_vld = (r_state == LOCKED) | w_rr.found;

  always_comb begin
    s_axis_in_tready = '0;
    if (rst && w_gnt_vld && w_skid_rdy)
      s_axis_in_tready[w_gnt] = 1'b1;
  end

  assign w_acc      = |(s_axis_in_tvalid & s_axis_in_tready);
  assign w_sel_data = s_axis_in_tdata[int'(w_gnt)*DATA_WIDTH +: DATA_WIDTH];
  assign w_sel_keep = (IF_STREAM != 0) ?
                      s_axis_in_tkeep[int'(w_gnt)*KEEP_WIDTH +: KEEP_WIDTH] : '1;
  assign w_sel_last = (IF_STREAM != 0) ? s_axis_in_tlast[w_gnt] : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= SIW'(SOURCE_COUNT - 1);
    end else if (w_acc) begin
      if (w_sel_last) begin
        r_state      <= IDLE;
        r_last_grant <= w_gnt;
      end else begin
        r_state <= LOCKED;
        r_grant <= w_gnt;
      end
    end
  end

`ifdef AXIS_MERGE_SRCID_EN
  assign w_in = {w_gnt, w_sel_last, w_sel_keep, w_sel_data};
  assign m_axis_out_tid = w_out[PW-1 -: SIW];
`else
  assign w_in = {w_sel_last, w_sel_keep, w_sel_data};
`endif

  assign {m_axis_out_tlast, m_axis_out_tkeep, m_axis_out_tdata} = w_out[BW-1:0];

  axis_skid_buffer #(
    .W(PW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_data  (w_in),
    .i_valid (w_acc),
    .o_ready (w_skid_rdy),
    .o_data  (w_out),
    .o_valid (m_axis_out_tvalid),
    .i_ready (m_axis_out_tready)
  );

endmodule

// File: tb/tb_axis_merge.sv
// Directed bench for axis_merge: a 2-source stream instance and a 4-source beat instance.
module tb_axis_merge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] s2_tdata;
  logic [3:0]  s2_tkeep;
  logic [1:0]  s2_tvalid, s2_tlast, s2_tready;
  logic [15:0] m2_tdata;
  logic [1:0]  m2_tkeep;
  logic        m2_tvalid, m2_tready, m2_tlast;

  logic [63:0] s4_tdata;
  logic [3:0]  s4_tkeep, s4_tvalid, s4_tlast, s4_tready;
  logic [15:0] m4_tdata;
  logic [0:0]  m4_tkeep;
  logic        m4_tvalid, m4_tready, m4_tlast;
`ifdef AXIS_MERGE_SRCID_EN
  logic [0:0]  m2_tid;
  logic [1:0]  m4_tid;
`endif

  axis_merge u_dut2 (
    .clk               (clk),
    .rst               (rst),
    .s_axis_in_tdata   (s2_tdata),
    .s_axis_in_tkeep   (s2_tkeep),
    .s_axis_in_tvalid  (s2_tvalid),
    .s_axis_in_tlast   (s2_tlast),
    .s_axis_in_tready  (s2_tready),
    .m_axis_out_tdata  (m2_tdata),
    .m_axis_out_tkeep  (m2_tkeep),
    .m_axis_out_tvalid (m2_tvalid),
    .m_axis_out_tready (m2_tready),
    .m_axis_out_tlast  (m2_tlast)
`ifdef AXIS_MERGE_SRCID_EN
    ,
    .m_axis_out_tid    (m2_tid)
`endif
  );

  axis_merge #(
    .IF_STREAM    (0),
    .SOURCE_COUNT (4)
  ) u_dut4 (
    .clk               (clk),
    .rst               (rst),
    .s_axis_in_tdata   (s4_tdata),
    .s_axis_in_tkeep   (s4_tkeep),
    .s_axis_in_tvalid  (s4_tvalid),
    .s_axis_in_tlast   (s4_tlast),
    .s_axis_in_tready  (s4_tready),
    .m_axis_out_tdata  (m4_tdata),
    .m_axis_out_tkeep  (m4_tkeep),
    .m_axis_out_tvalid (m4_tvalid),
    .m_axis_out_tready (m4_tready),
    .m_axis_out_tlast  (m4_tlast)
`ifdef AXIS_MERGE_SRCID_EN
    ,
    .m_axis_out_tid    (m4_tid)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Source queue entry: {keep[1:0], last, data[15:0]}
  logic [18:0] qa[$];
  logic [18:0] qb[$];
  logic [19:0] exp2[$];
  logic [17:0] exp4[$];

  int          pa, bp, bp_acc, cyc, t_first, t_last, n_out4, tot4;
  int          cnt4[4];
  logic        held_ok, a_inframe, run4;
  logic [18:0] held;

  task automatic push_a(input logic [15:0] d, input logic l,
                        input logic [1:0] k);
    qa.push_back({k, l, d});
    exp2.push_back({1'b0, k, l, d});
  endtask

  task automatic push_b(input logic [15:0] d, input logic l,
                        input logic [1:0] k);
    qb.push_back({k, l, d});
    exp2.push_back({1'b1, k, l, d});
  endtask

  task automatic drive();
    s2_tvalid = '0;
    s2_tdata  = '0;
    s2_tlast  = '0;
    s2_tkeep  = '0;
    if (qa.size() > 0 && pa == 0) begin
      s2_tvalid[0]     = 1'b1;
      s2_tdata[15:0]   = qa[0][15:0];
      s2_tlast[0]      = qa[0][16];
      s2_tkeep[1:0]    = qa[0][18:17];
    end
    if (qb.size() > 0) begin
      s2_tvalid[1]     = 1'b1;
      s2_tdata[31:16]  = qb[0][15:0];
      s2_tlast[1]      = qb[0][16];
      s2_tkeep[3:2]    = qb[0][18:17];
    end
    s4_tvalid = (run4 && tot4 < 12) ? 4'hF : 4'h0;
    s4_tkeep  = '0;
    s4_tlast  = '0;
    for (int i = 0; i < 4; i++)
      s4_tdata[i*16 +: 16] = 16'h4000 | 16'(i << 8) | 16'(cnt4[i]);
  endtask

  task automatic tick();
    logic [1:0]  acc2;
    logic [3:0]  acc4;
    logic [18:0] d;
    logic [19:0] e2;
    logic [17:0] e4;
    @(negedge clk);
    cyc++;
    acc2 = s2_tvalid & s2_tready;
    acc4 = s4_tvalid & s4_tready;
    if (a_inframe) check("b_blocked", 32'(s2_tready[1]), 0);
    if (!m2_tready) begin
      if (acc2 != 0) bp_acc++;
      if (m2_tvalid) begin
        if (held_ok)
          check("bp_hold", {m2_tkeep, m2_tlast, m2_tdata}, held);
        else begin
          held    = {m2_tkeep, m2_tlast, m2_tdata};
          held_ok = 1'b1;
        end
      end
    end
    if (m2_tvalid && m2_tready) begin
      if (exp2.size() == 0) check("m2_extra", 1, 0);
      else begin
        e2 = exp2.pop_front();
        check("m2_beat", {m2_tkeep, m2_tlast, m2_tdata}, e2[18:0]);
`ifdef AXIS_MERGE_SRCID_EN
        check("m2_tid", 32'(m2_tid), 32'(e2[19]));
`endif
      end
    end
    if (m4_tvalid && m4_tready) begin
      if (exp4.size() == 0) check("m4_extra", 1, 0);
      else begin
        e4 = exp4.pop_front();
        check("m4_beat", {m4_tlast, m4_tkeep, m4_tdata}, {2'b11, e4[15:0]});
`ifdef AXIS_MERGE_SRCID_EN
        check("m4_tid", 32'(m4_tid), 32'(e4[17:16]));
`endif
        if (n_out4 == 0) t_first = cyc;
        t_last = cyc;
        n_out4++;
      end
    end
    @(posedge clk);
    #1;
    if (pa > 0) pa--;
    if (acc2[0]) begin
      d = qa.pop_front();
      a_inframe = !d[16];
      if (d[15:0] == 16'hA003) pa = 4;
    end
    if (acc2[1]) void'(qb.pop_front());
    for (int i = 0; i < 4; i++)
      if (acc4[i]) begin
        cnt4[i]++;
        tot4++;
      end
    if (bp > 0) bp--;
    m2_tready = (bp == 0);
    drive();
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp2.size() > 0 || exp4.size() > 0) && n < 60) begin
      tick();
      n++;
    end
    check(tag, exp2.size() + exp4.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b0;
    pa = 0; bp = 0; bp_acc = 0; cyc = 0; n_out4 = 0; tot4 = 0;
    t_first = 0; t_last = 0;
    for (int i = 0; i < 4; i++) cnt4[i] = 0;
    held = '0; held_ok = 1'b0; a_inframe = 1'b0; run4 = 1'b0;
    m2_tready = 1'b1;
    m4_tready = 1'b1;

    push_a(16'hA000, 1'b0, 2'b11);
    push_a(16'hA001, 1'b0, 2'b11);
    push_a(16'hA002, 1'b1, 2'b11);
    push_b(16'hB000, 1'b0, 2'b11);
    push_b(16'hB001, 1'b1, 2'b01);
    drive();

    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_rdy2", 32'(s2_tready), 0);
      check("rst_vld2", 32'(m2_tvalid), 0);
    end
    check("rst_out2", {m2_tkeep, m2_tlast, m2_tdata}, 0);
    check("rst_vld4", 32'(m4_tvalid), 0);
    check("rst_rdy4", 32'(s4_tready), 0);

    rst = 1'b1;
    #1;
    check("first_src", 32'(s2_tready), 32'h1);
    wait_drain("frames_drain");

    push_a(16'hA003, 1'b0, 2'b11);
    push_a(16'hA004, 1'b0, 2'b11);
    push_a(16'hA005, 1'b1, 2'b10);
    push_b(16'hB002, 1'b0, 2'b11);
    push_b(16'hB003, 1'b1, 2'b11);
    drive();
    wait_drain("stall_drain");

    bp = 5;
    m2_tready = 1'b0;
    held_ok = 1'b0;
    bp_acc = 0;
    for (int i = 0; i < 6; i++)
      push_a(16'hC000 | 16'(i), (i == 5), 2'b11);
    drive();
    wait_drain("bp_drain");
    check("bp_acc", bp_acc, 2);

    for (int n = 0; n < 12; n++)
      exp4.push_back({2'(n % 4), 16'h4000 | 16'((n % 4) << 8) | 16'(n / 4)});
    run4 = 1'b1;
    drive();
    wait_drain("rr_drain");
    check("rr_count", n_out4, 12);
    check("rr_thru", t_last - t_first, 11);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
